// File: rtl/ep2_pkg.sv
// Shared constants and state encoding for the EP2 frame parser.
package ep2_pkg;
    localparam logic [7:0] SYNC_BYTE    = 8'h7F;
    localparam int         SYNC_LEN     = 3;
    localparam int         CTRL_LEN     = 5;
    localparam int         PAYLOAD_LEN  = 504;
    localparam int         SAMPLE_BYTES = 8;

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        SYNC    = 2'd1,
        CTRL    = 2'd2,
        PAYLOAD = 2'd3
    } state_t;
endpackage

// File: rtl/ep2_sample_assembler.sv
// Packs 8 payload bytes (L,R,I,Q big-endian) per sample; valid pulses 1 cycle after the 8th byte.
// No backpressure; audio storage only when EP2_AUDIO_EN is defined.
module ep2_sample_assembler
    import ep2_pkg::*;
(
    input  logic        rx_clock,
    input  logic        rst_n,
    input  logic        i_clr,
    input  logic        i_byte_vld,
    input  logic [7:0]  i_byte_dat,
    output logic        o_iq_vld,
    output logic [15:0] o_tx_i,
    output logic [15:0] o_tx_q,
    output logic        o_audio_vld,
    output logic [15:0] o_audio_l,
    output logic [15:0] o_audio_r
);
`ifdef EP2_AUDIO_EN
    localparam int SH_W = 56;
`else
    // Audio bytes still pass through the shifter but fall off the top unstored.
    localparam int SH_W = 24;
`endif

    logic [2:0]      r_idx;
    logic [SH_W-1:0] r_shift;
    logic            r_iq_vld;
    logic [15:0]     r_tx_i;
    logic [15:0]     r_tx_q;
    logic [SH_W+7:0] w_sample;
    logic            w_last;

    assign w_sample = {r_shift, i_byte_dat};
    assign w_last   = i_byte_vld && !i_clr && (r_idx == 3'(SAMPLE_BYTES - 1));

    always_ff @(posedge rx_clock or negedge rst_n) begin
        if (!rst_n) begin
            r_idx    <= 3'd0;
            r_shift  <= '0;
            r_iq_vld <= 1'b0;
            r_tx_i   <= 16'h0000;
            r_tx_q   <= 16'h0000;
        end else begin
            r_iq_vld <= 1'b0;
            if (i_clr) begin
                r_idx <= 3'd0;
            end else if (i_byte_vld) begin
                r_shift <= w_sample[SH_W-1:0];
                r_idx   <= r_idx + 3'd1;
                if (w_last) begin
                    r_iq_vld <= 1'b1;
                    r_tx_i   <= w_sample[31:16];
                    r_tx_q   <= w_sample[15:0];
                end
            end
        end
    end

    assign o_iq_vld = r_iq_vld;
    assign o_tx_i   = r_tx_i;
    assign o_tx_q   = r_tx_q;

`ifdef EP2_AUDIO_EN
    logic        r_audio_vld;
    logic [15:0] r_audio_l;
    logic [15:0] r_audio_r;

    always_ff @(posedge rx_clock or negedge rst_n) begin
        if (!rst_n) begin
            r_audio_vld <= 1'b0;
            r_audio_l   <= 16'h0000;
            r_audio_r   <= 16'h0000;
        end else begin
            r_audio_vld <= w_last;
            if (w_last) begin
                r_audio_l <= w_sample[63:48];
                r_audio_r <= w_sample[47:32];
            end
        end
    end

    assign o_audio_vld = r_audio_vld;
    assign o_audio_l   = r_audio_l;
    assign o_audio_r   = r_audio_r;
`else
    assign o_audio_vld = 1'b0;
    assign o_audio_l   = 16'h0000;
    assign o_audio_r   = 16'h0000;
`endif
endmodule

// File: rtl/ep2_frame_parser.sv
// EP2 512-byte frame parser: sync hunt, control capture, sample unpack; all outputs 1 cycle after
// the accepted byte, no backpressure. Define EP2_AUDIO_EN to capture L/R audio.
module ep2_frame_parser
    import ep2_pkg::*;
#(
    parameter int SYNC_ERR_W = 8
) (
    input  logic                  rx_clock,
    input  logic                  rst_n,
    input  logic                  run,
    input  logic                  rx_fifo_enable,
    input  logic [7:0]            rx_fifo_data,
    output logic                  cmd_valid,
    output logic [5:0]            cmd_addr,
    output logic                  ptt,
    output logic [31:0]           cmd_data,
    output logic                  iq_valid,
    output logic [15:0]           tx_i,
    output logic [15:0]           tx_q,
    output logic                  audio_valid,
    output logic [15:0]           audio_l,
    output logic [15:0]           audio_r,
    output logic                  in_sync,
    output logic [SYNC_ERR_W-1:0] sync_err
);
    state_t                r_state, w_state_nxt;
    logic [1:0]            r_sync_cnt, w_sync_cnt_nxt;
    logic [2:0]            r_ctrl_cnt, w_ctrl_cnt_nxt;
    logic [8:0]            r_pay_cnt, w_pay_cnt_nxt;
    logic                  r_in_sync;
    logic [SYNC_ERR_W-1:0] r_sync_err;
    logic [6:0]            r_c0;
    logic [23:0]           r_cbuf;
    logic                  r_cmd_valid;
    logic [5:0]            r_cmd_addr;
    logic                  r_ptt;
    logic [31:0]           r_cmd_data;
    logic                  w_byte_acc;
    logic                  w_sync_loss;
    logic                  w_ctrl_done;
    logic                  w_pay_vld;
    logic                  w_asm_clr;

    assign w_byte_acc = run && rx_fifo_enable;

    always_comb begin
        w_state_nxt    = r_state;
        w_sync_cnt_nxt = r_sync_cnt;
        w_ctrl_cnt_nxt = r_ctrl_cnt;
        w_pay_cnt_nxt  = r_pay_cnt;
        w_sync_loss    = 1'b0;
        w_ctrl_done    = 1'b0;
        w_pay_vld      = 1'b0;
        if (!run) begin
            w_state_nxt    = HUNT;
            w_sync_cnt_nxt = 2'd0;
            w_ctrl_cnt_nxt = 3'd0;
            w_pay_cnt_nxt  = 9'd0;
        end else if (rx_fifo_enable) begin
            case (r_state)
                HUNT: begin
                    if (rx_fifo_data == SYNC_BYTE) begin
                        w_state_nxt    = SYNC;
                        w_sync_cnt_nxt = 2'd1;
                    end
                end
                SYNC: begin
                    if (rx_fifo_data != SYNC_BYTE) begin
                        w_state_nxt    = HUNT;
                        w_sync_cnt_nxt = 2'd0;
                        w_sync_loss    = 1'b1;
                    end else if (r_sync_cnt == 2'(SYNC_LEN - 1)) begin
                        w_state_nxt    = CTRL;
                        w_sync_cnt_nxt = 2'd0;
                        w_ctrl_cnt_nxt = 3'd0;
                    end else begin
                        w_sync_cnt_nxt = r_sync_cnt + 2'd1;
                    end
                end
                CTRL: begin
                    if (r_ctrl_cnt == 3'(CTRL_LEN - 1)) begin
                        w_state_nxt    = PAYLOAD;
                        w_ctrl_cnt_nxt = 3'd0;
                        w_pay_cnt_nxt  = 9'd0;
                        w_ctrl_done    = 1'b1;
                    end else begin
                        w_ctrl_cnt_nxt = r_ctrl_cnt + 3'd1;
                    end
                end
                PAYLOAD: begin
                    // Sync bytes here are ordinary data; only the byte count ends the frame.
                    w_pay_vld = 1'b1;
                    if (r_pay_cnt == 9'(PAYLOAD_LEN - 1)) begin
                        w_state_nxt    = SYNC;
                        w_sync_cnt_nxt = 2'd0;
                        w_pay_cnt_nxt  = 9'd0;
                    end else begin
                        w_pay_cnt_nxt = r_pay_cnt + 9'd1;
                    end
                end
                default: w_state_nxt = HUNT;
            endcase
        end
    end

    always_ff @(posedge rx_clock or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= HUNT;
            r_sync_cnt <= 2'd0;
            r_ctrl_cnt <= 3'd0;
            r_pay_cnt  <= 9'd0;
            r_in_sync  <= 1'b0;
            r_sync_err <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_sync_cnt <= w_sync_cnt_nxt;
            r_ctrl_cnt <= w_ctrl_cnt_nxt;
            r_pay_cnt  <= w_pay_cnt_nxt;
            if (w_state_nxt == HUNT)
                r_in_sync <= 1'b0;
            else if (w_state_nxt == CTRL)
                r_in_sync <= 1'b1;
            // Losing sync before ever locking is not an error; the counter sticks at all-ones.
            if (w_sync_loss && r_in_sync && (r_sync_err != {SYNC_ERR_W{1'b1}}))
                r_sync_err <= r_sync_err + SYNC_ERR_W'(1);
        end
    end

    always_ff @(posedge rx_clock or negedge rst_n) begin
        if (!rst_n) begin
            r_c0        <= 7'd0;
            r_cbuf      <= 24'd0;
            r_cmd_valid <= 1'b0;
            r_cmd_addr  <= 6'd0;
            r_ptt       <= 1'b0;
            r_cmd_data  <= 32'd0;
        end else begin
            r_cmd_valid <= 1'b0;
            if (w_byte_acc && (r_state == CTRL)) begin
                if (r_ctrl_cnt == 3'd0) begin
                    r_c0 <= rx_fifo_data[6:0];
                end else if (w_ctrl_done) begin
                    r_cmd_valid <= 1'b1;
                    r_cmd_addr  <= r_c0[6:1];
                    r_ptt       <= r_c0[0];
                    r_cmd_data  <= {r_cbuf, rx_fifo_data};
                end else begin
                    r_cbuf <= {r_cbuf[15:0], rx_fifo_data};
                end
            end
        end
    end

    assign w_asm_clr = !run || (r_state != PAYLOAD);

    ep2_sample_assembler u_asm (
        .rx_clock    (rx_clock),
        .rst_n       (rst_n),
        .i_clr       (w_asm_clr),
        .i_byte_vld  (w_pay_vld),
        .i_byte_dat  (rx_fifo_data),
        .o_iq_vld    (iq_valid),
        .o_tx_i      (tx_i),
        .o_tx_q      (tx_q),
        .o_audio_vld (audio_valid),
        .o_audio_l   (audio_l),
        .o_audio_r   (audio_r)
    );

    assign cmd_valid = r_cmd_valid;
    assign cmd_addr  = r_cmd_addr;
    assign ptt       = r_ptt;
    assign cmd_data  = r_cmd_data;
    assign in_sync   = r_in_sync;
    assign sync_err  = r_sync_err;
endmodule

// File: tb/tb_ep2_frame_parser.sv
// Directed bench for ep2_frame_parser; a second 2-bit sync_err instance exercises saturation.
module tb_ep2_frame_parser;
    logic        rx_clock;
    logic        rst_n;
    logic        run;
    logic        rx_fifo_enable;
    logic [7:0]  rx_fifo_data;
    logic        cmd_valid, ptt, iq_valid, audio_valid, in_sync;
    logic [5:0]  cmd_addr;
    logic [31:0] cmd_data;
    logic [15:0] tx_i, tx_q, audio_l, audio_r;
    logic [7:0]  sync_err;
    logic        n_cmd_valid, n_ptt, n_iq_valid, n_audio_valid, n_in_sync;
    logic [5:0]  n_cmd_addr;
    logic [31:0] n_cmd_data;
    logic [15:0] n_tx_i, n_tx_q, n_audio_l, n_audio_r;
    logic [1:0]  n_sync_err;

    int n_vec = 0;
    int n_err = 0;
    int c_cmd = 0;
    int c_iq  = 0;
    int c_aud = 0;

`ifdef EP2_AUDIO_EN
    localparam int AUD_PER_FRAME = 63;
`else
    localparam int AUD_PER_FRAME = 0;
`endif

    ep2_frame_parser u_dut (
        .rx_clock(rx_clock), .rst_n(rst_n), .run(run),
        .rx_fifo_enable(rx_fifo_enable), .rx_fifo_data(rx_fifo_data),
        .cmd_valid(cmd_valid), .cmd_addr(cmd_addr), .ptt(ptt), .cmd_data(cmd_data),
        .iq_valid(iq_valid), .tx_i(tx_i), .tx_q(tx_q),
        .audio_valid(audio_valid), .audio_l(audio_l), .audio_r(audio_r),
        .in_sync(in_sync), .sync_err(sync_err)
    );

    ep2_frame_parser #(.SYNC_ERR_W(2)) u_dut_w2 (
        .rx_clock(rx_clock), .rst_n(rst_n), .run(run),
        .rx_fifo_enable(rx_fifo_enable), .rx_fifo_data(rx_fifo_data),
        .cmd_valid(n_cmd_valid), .cmd_addr(n_cmd_addr), .ptt(n_ptt), .cmd_data(n_cmd_data),
        .iq_valid(n_iq_valid), .tx_i(n_tx_i), .tx_q(n_tx_q),
        .audio_valid(n_audio_valid), .audio_l(n_audio_l), .audio_r(n_audio_r),
        .in_sync(n_in_sync), .sync_err(n_sync_err)
    );

    initial rx_clock = 1'b0;
    always #5 rx_clock = ~rx_clock;

    // Sample s: L=s+1, R=s+2, I=0x1234+s, Q=0xFEDC-s, each MSB first.
    function automatic logic [7:0] pbyte(input int s, input int j);
        logic [63:0] w;
        w = {16'(s + 1), 16'(s + 2), 16'(16'h1234 + s), 16'(16'hFEDC - s)};
        return w[63 - 8*j -: 8];
    endfunction

    task automatic tally();
        if (cmd_valid)   c_cmd++;
        if (iq_valid)    c_iq++;
        if (audio_valid) c_aud++;
    endtask

    task automatic put(input logic [7:0] b);
        rx_fifo_data   = b;
        rx_fifo_enable = 1'b1;
        @(posedge rx_clock);
        #1;
        rx_fifo_enable = 1'b0;
        tally();
    endtask

    task automatic idle(input logic [7:0] junk);
        rx_fifo_data   = junk;
        rx_fifo_enable = 1'b0;
        @(posedge rx_clock);
        #1;
        tally();
    endtask

    task automatic send_frame(input logic [7:0] c0, input logic [31:0] c14, input bit all_sync);
        for (int k = 0; k < 3; k++) put(8'h7F);
        put(c0);
        for (int k = 0; k < 4; k++) put(c14[31 - 8*k -: 8]);
        for (int s = 0; s < 63; s++)
            for (int j = 0; j < 8; j++) put(all_sync ? 8'h7F : pbyte(s, j));
    endtask

    task automatic test_reset();
        repeat (2) @(posedge rx_clock);
        #1;
        n_vec++; if ({cmd_valid, iq_valid, audio_valid, in_sync, ptt} !== 5'b0) begin n_err++;
            $display("FAIL reset_flags: got %b want 00000", {cmd_valid, iq_valid, audio_valid, in_sync, ptt}); end
        n_vec++; if ({cmd_addr, cmd_data} !== 38'd0) begin n_err++;
            $display("FAIL reset_cmd: got %h/%h want 0/0", cmd_addr, cmd_data); end
        n_vec++; if ({tx_i, tx_q, audio_l, audio_r} !== 64'd0) begin n_err++;
            $display("FAIL reset_samples: got %h want 0", {tx_i, tx_q, audio_l, audio_r}); end
        n_vec++; if (sync_err !== 8'd0) begin n_err++;
            $display("FAIL reset_sync_err: got %0d want 0", sync_err); end
        rst_n = 1'b1;
        idle(8'h7F);
    endtask

    task automatic test_clean_frame();
        c_cmd = 0; c_iq = 0; c_aud = 0;
        put(8'h7F); idle(8'h00); put(8'h7F);
        n_vec++; if (in_sync !== 1'b0) begin n_err++;
            $display("FAIL clean_insync_early: got %b want 0", in_sync); end
        put(8'h7F);
        n_vec++; if (in_sync !== 1'b1) begin n_err++;
            $display("FAIL clean_insync_lock: got %b want 1", in_sync); end
        put(8'h13); put(8'hDE); put(8'hAD); put(8'hBE); put(8'hEF);
        n_vec++; if (cmd_valid !== 1'b1) begin n_err++;
            $display("FAIL clean_cmd_pulse: got %b want 1", cmd_valid); end
        n_vec++; if ({cmd_addr, ptt, cmd_data} !== {6'h09, 1'b1, 32'hDEADBEEF}) begin n_err++;
            $display("FAIL clean_cmd_fields: got %h/%b/%h want 09/1/deadbeef", cmd_addr, ptt, cmd_data); end
        for (int s = 0; s < 63; s++) begin
            for (int j = 0; j < 8; j++) begin
                put(pbyte(s, j));
                if (s == 0 && j == 0) begin
                    n_vec++; if (cmd_valid !== 1'b0) begin n_err++;
                        $display("FAIL clean_cmd_one_cycle: got %b want 0", cmd_valid); end
                end
                if (s == 0 && j == 7) begin
                    n_vec++; if ({iq_valid, tx_i, tx_q} !== {1'b1, 16'h1234, 16'hFEDC}) begin n_err++;
                        $display("FAIL clean_iq_first: got %b/%h/%h want 1/1234/fedc", iq_valid, tx_i, tx_q); end
`ifdef EP2_AUDIO_EN
                    n_vec++; if ({audio_valid, audio_l, audio_r} !== {1'b1, 16'h0001, 16'h0002}) begin n_err++;
                        $display("FAIL clean_audio_first: got %b/%h/%h want 1/0001/0002", audio_valid, audio_l, audio_r); end
`else
                    n_vec++; if ({audio_valid, audio_l, audio_r} !== 33'd0) begin n_err++;
                        $display("FAIL clean_audio_off: got %b/%h/%h want 0/0/0", audio_valid, audio_l, audio_r); end
`endif
                end
                if (s == 1 && j == 1) begin
                    n_vec++; if ({iq_valid, tx_i, tx_q} !== {1'b0, 16'h1234, 16'hFEDC}) begin n_err++;
                        $display("FAIL clean_iq_hold: got %b/%h/%h want 0/1234/fedc", iq_valid, tx_i, tx_q); end
                end
                if (j == 3) idle(8'h7F);
            end
        end
        n_vec++; if (c_cmd !== 1) begin n_err++; $display("FAIL clean_cmd_count: got %0d want 1", c_cmd); end
        n_vec++; if (c_iq !== 63) begin n_err++; $display("FAIL clean_iq_count: got %0d want 63", c_iq); end
        n_vec++; if (c_aud !== AUD_PER_FRAME) begin n_err++;
            $display("FAIL clean_audio_count: got %0d want %0d", c_aud, AUD_PER_FRAME); end
        n_vec++; if ({tx_i, tx_q} !== {16'h1272, 16'hFE9E}) begin n_err++;
            $display("FAIL clean_iq_last: got %h/%h want 1272/fe9e", tx_i, tx_q); end
    endtask

    task automatic test_back_to_back();
        c_cmd = 0; c_iq = 0;
        send_frame(8'h82, 32'h01234567, 1'b1);
        n_vec++; if ({c_cmd, c_iq} !== {32'd1, 32'd63}) begin n_err++;
            $display("FAIL b2b_counts: got cmd=%0d iq=%0d want 1/63", c_cmd, c_iq); end
        n_vec++; if ({cmd_addr, ptt, cmd_data} !== {6'h01, 1'b0, 32'h01234567}) begin n_err++;
            $display("FAIL b2b_cmd: got %h/%b/%h want 01/0/01234567", cmd_addr, ptt, cmd_data); end
        n_vec++; if ({tx_i, tx_q, in_sync, sync_err} !== {32'h7F7F7F7F, 1'b1, 8'd0}) begin n_err++;
            $display("FAIL b2b_sync_data: got %h/%h/%b/%0d want 7f7f/7f7f/1/0", tx_i, tx_q, in_sync, sync_err); end
    endtask

    task automatic test_sync_loss();
        put(8'h7F); put(8'h7F); put(8'h00);
        n_vec++; if ({in_sync, sync_err} !== {1'b0, 8'd1}) begin n_err++;
            $display("FAIL loss_detect: got in_sync=%b err=%0d want 0/1", in_sync, sync_err); end
        c_cmd = 0;
        put(8'h00); put(8'h42);
        send_frame(8'h13, 32'hCAFEF00D, 1'b0);
        n_vec++; if ({c_cmd, cmd_data, in_sync} !== {32'd1, 32'hCAFEF00D, 1'b1}) begin n_err++;
            $display("FAIL loss_resync: got cmd=%0d data=%h in_sync=%b want 1/cafef00d/1", c_cmd, cmd_data, in_sync); end
    endtask

    task automatic test_run_low();
        c_cmd = 0; c_iq = 0;
        for (int k = 0; k < 3; k++) put(8'h7F);
        put(8'h13); put(8'h01); put(8'h02); put(8'h03); put(8'h04);
        for (int b = 0; b < 200; b++) put(pbyte(b / 8, b % 8));
        n_vec++; if (c_iq !== 25) begin n_err++; $display("FAIL run_pre_iq: got %0d want 25", c_iq); end
        run = 1'b0;
        put(pbyte(25, 0));
        n_vec++; if ({in_sync, iq_valid} !== 2'b00) begin n_err++;
            $display("FAIL run_low_hunt: got in_sync=%b iq=%b want 0/0", in_sync, iq_valid); end
        run = 1'b1;
        c_iq = 0; c_cmd = 0;
        for (int b = 201; b < 504; b++) put(8'h11);
        n_vec++; if ({c_iq, c_cmd} !== 64'd0) begin n_err++;
            $display("FAIL run_no_more: got iq=%0d cmd=%0d want 0/0", c_iq, c_cmd); end
        n_vec++; if ({sync_err, in_sync} !== {8'd1, 1'b0}) begin n_err++;
            $display("FAIL run_err_kept: got err=%0d in_sync=%b want 1/0", sync_err, in_sync); end
    endtask

    task automatic test_reset_mid_ctrl();
        for (int k = 0; k < 3; k++) put(8'h7F);
        put(8'h13); put(8'hDE);
        rst_n = 1'b0;
        #2;
        n_vec++; if ({in_sync, sync_err, cmd_data} !== 41'd0) begin n_err++;
            $display("FAIL rst_mid_clear: got %b/%0d/%h want 0/0/0", in_sync, sync_err, cmd_data); end
        @(posedge rx_clock);
        #1;
        rst_n = 1'b1;
        c_cmd = 0;
        put(8'hAD); put(8'hBE); put(8'hEF);
        for (int k = 0; k < 20; k++) put(8'h22);
        n_vec++; if (c_cmd !== 0) begin n_err++; $display("FAIL rst_partial_cmd: got %0d want 0", c_cmd); end
        send_frame(8'h55, 32'h11223344, 1'b0);
        n_vec++; if ({c_cmd, cmd_addr, ptt, cmd_data} !== {32'd1, 6'h2A, 1'b1, 32'h11223344}) begin n_err++;
            $display("FAIL rst_new_frame: got %0d/%h/%b/%h want 1/2a/1/11223344", c_cmd, cmd_addr, ptt, cmd_data); end
    endtask

    task automatic test_saturation();
        for (int k = 1; k <= 6; k++) begin
            put(8'h00);
            n_vec++; if (sync_err !== 8'(k)) begin n_err++;
                $display("FAIL sat_wide_%0d: got %0d want %0d", k, sync_err, k); end
            n_vec++; if (n_sync_err !== 2'((k > 3) ? 3 : k)) begin n_err++;
                $display("FAIL sat_narrow_%0d: got %0d want %0d", k, n_sync_err, (k > 3) ? 3 : k); end
            send_frame(8'h00, 32'h0, 1'b0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        run = 1'b1;
        rx_fifo_enable = 1'b0;
        rx_fifo_data = 8'h00;
        test_reset();
        test_clean_frame();
        test_back_to_back();
        test_sync_loss();
        test_run_low();
        test_reset_mid_ctrl();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
